country_sensor_interface: RTL and testbench
===========================================

# country_sensor_interface

Vehicle-detection front end for the highway/country traffic controller, sitting on the country-road side of its `x` car-present input. It synchronizes and debounces the raw inductive-loop signal, latches a service request, and drives `x` to the controller. It watches the controller's `Country` light output to learn when the request has been served, then clears the request. It also counts vehicles that arrive while a request is pending.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the filtered loop level changes; legal range 1–255.
- `MIN_SERVE_CYCLES`, default 8: cycles `x` is held high after country green is granted, regardless of loop level; legal range 1–255.
- `CNT_W`, default 8: width of `car_count`.
- `GREEN_CODE`, default 2'b10: encoding of green on the controller's light buses. Red is 2'b00 and yellow is 2'b01.

Ports:
- `clk`, input, 1: single system clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `loop_raw`, input, 1: raw loop detector; asynchronous to `clk` and may glitch.
- `country_light`, input, 2: the controller's `Country` output.
- `x`, output, 1: car-present request to the controller; registered.
- `car_count`, output, `CNT_W`: number of vehicles seen in the current request; saturates at all-ones.
- `served_pulse`, output, 1: one-cycle strobe when a request completes.
- `state`, output, 2: current FSM state, for debug.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`, on `loop_raw`.
- **Debounce counter:**
  - While `s2` differs from `filt`, the counter increments.
  - When `s2` has differed for `DEBOUNCE_CYCLES` consecutive cycles, `filt` takes `s2` and the counter clears.
  - Any cycle with `s2 == filt` clears the counter.
- **Arrival event:** a 0→1 transition of `filt`.
- **IDLE (2'b00):**
  - `x` = 0.
  - On arrival: go to REQ and set `car_count` = 1.
- **REQ (2'b01):**
  - `x` = 1.
  - Each arrival increments `car_count`, saturating.
  - When `country_light == GREEN_CODE`: go to SERVE and load the serve timer with `MIN_SERVE_CYCLES`.
  - If an arrival and green occur in the same cycle, the count increments and the state still goes to SERVE.
- **SERVE (2'b10):**
  - `x` = 1 while the serve timer is nonzero.
  - Once the timer reaches 0, `x` = `filt`.
  - Go to CLEAR when either:
    - the timer is 0 and `filt` = 0, or
    - `country_light != GREEN_CODE` (controller pre-empted).
  - Arrivals do not change `car_count` in SERVE.
- **CLEAR (2'b11):**
  - `x` = 0.
  - `served_pulse` = 1 only in the first cycle of CLEAR.
  - `car_count` clears to 0 on entry.
  - When `country_light != GREEN_CODE`: go to REQ with `car_count` = 1 if an arrival was latched during CLEAR, otherwise go to IDLE.
  - An arrival in the exit cycle counts as latched.
- **Outputs:** `x`, `car_count`, `served_pulse` and `state` are registered, derived from the next state.
- **Reset:** `rst` = 1 forces all of the following to 0 at the next edge, with priority over every other event, including mid-request:
  - `s1`, `s2`, `filt`, the debounce counter and the serve timer;
  - the pending-arrival latch;
  - `state` (IDLE), `x`, `car_count` and `served_pulse`.

## Timing
- **Request latency:** when `loop_raw` first rises before clock edge E1 and stays high, `s2` is 1 after E2, `filt` is 1 after E(2+`DEBOUNCE_CYCLES`), and `x` is 1 after E(3+`DEBOUNCE_CYCLES`). With the default, that is 7 edges.
- **Glitch rejection:** a `loop_raw` pulse of `DEBOUNCE_CYCLES`−1 cycles or fewer, as seen at `s2`, never changes `filt`.
- **REQ→SERVE:** occurs 1 cycle after `country_light` first samples `GREEN_CODE`. `x` stays high across the transition.
- **Serve hold:** `x` is guaranteed high for at least `MIN_SERVE_CYCLES` cycles after SERVE entry, unless green is withdrawn.
- **`served_pulse`:** exactly 1 cycle wide, coincident with the first cycle of CLEAR.
- **Minimum request cycle:** IDLE→REQ→SERVE→CLEAR→IDLE takes at least 3 + `MIN_SERVE_CYCLES` cycles.

## Test plan
- **Reset:** hold `rst` = 1 for 3 cycles with `loop_raw` = 1 → `x` = 0, `state` = 00 and `car_count` = 0 throughout. Release `rst` → `x` rises 7 edges later.
- **Glitch:** with `DEBOUNCE_CYCLES` = 4, drive 3-cycle pulses on `loop_raw` separated by 3 low cycles, 5 times → `x` stays 0 and `state` stays 00.
- **Full service:**
  - Car arrives → `x` = 1 and `car_count` = 1.
  - After 10 cycles, drive `country_light` = 2'b10 → `state` = 10.
  - Drop `loop_raw` immediately → `x` holds 1 for 8 cycles, then falls once `filt` falls.
  - `served_pulse` fires once.
  - Set `country_light` = 2'b00 → `state` = 00.
- **Counting and saturation:** with `CNT_W` = 2, make 5 distinct arrivals in REQ → `car_count` reads 1, 2, 3, 3, 3. Grant green → `car_count` clears to 0 at CLEAR.
- **Arrival during CLEAR:**
  - Make a new arrival while `country_light` is still 2'b10 in CLEAR.
  - Then set red → next state is REQ, `x` = 1, `car_count` = 1, with no IDLE cycle.
- **Pre-emption and mid-operation reset:**
  - In SERVE with the timer at 5, set `country_light` = 2'b01 → CLEAR next cycle and `served_pulse` = 1.
  - Separately, assert `rst` in REQ → all outputs are 0 at the next edge.

Source files
------------

// File: rtl/country_sensor_interface.sv
`default_nettype none
// ============================================================================
// Module      : country_sensor_interface
// Description : Loop-detector front end for the country road. Synchronizes and
//               debounces the raw loop, raises x until the request is served,
//               and counts vehicles that arrive while a request is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module country_sensor_interface #(
    parameter int         DEBOUNCE_CYCLES  = 4,
    parameter int         MIN_SERVE_CYCLES = 8,
    parameter int         CNT_W            = 8,
    parameter logic [1:0] GREEN_CODE       = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             loop_raw,
    input  logic [1:0]       country_light,
    output logic             x,
    output logic [CNT_W-1:0] car_count,
    output logic             served_pulse,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        SERVE = 2'b10,
        CLEAR = 2'b11
    } state_t;

    localparam logic [7:0]       c_deb_last   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       c_serve_load = 8'(MIN_SERVE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    logic             r_s1, r_s2, r_filt, r_filt_d;
    logic [7:0]       r_deb_cnt;
    logic [7:0]       r_timer;
    logic             r_latch;
    state_t           r_state;
    logic             r_x, r_served_pulse;
    logic [CNT_W-1:0] r_car_count;

    logic             w_filt_next, w_flip, w_arrival, w_green;
    state_t           w_state_next;
    logic [7:0]       w_timer_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_latch_next;

    // filt only moves after s2 has disagreed with it for DEBOUNCE_CYCLES samples
    assign w_flip      = (r_s2 != r_filt) && (r_deb_cnt == c_deb_last);
    assign w_filt_next = w_flip ? r_s2 : r_filt;
    assign w_arrival   = r_filt & ~r_filt_d;
    assign w_green     = (country_light == GREEN_CODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_filt    <= 1'b0;
            r_filt_d  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_s1     <= loop_raw;
            r_s2     <= r_s1;
            r_filt   <= w_filt_next;
            r_filt_d <= r_filt;
            if (r_s2 != r_filt && !w_flip) begin
                r_deb_cnt <= r_deb_cnt + 8'd1;
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_cnt_next   = r_car_count;
        w_latch_next = r_latch;
        unique case (r_state)
            IDLE: begin
                if (w_arrival) begin
                    w_state_next = REQ;
                    w_cnt_next   = c_cnt_one;
                end
            end
            REQ: begin
                if (w_arrival && r_car_count != c_cnt_max) begin
                    w_cnt_next = r_car_count + c_cnt_one;
                end
                if (w_green) begin
                    w_state_next = SERVE;
                    w_timer_next = c_serve_load;
                end
            end
            SERVE: begin
                if (r_timer != '0) begin
                    w_timer_next = r_timer - 8'd1;
                end
                if (!w_green || (r_timer == '0 && !r_filt)) begin
                    w_state_next = CLEAR;
                    w_cnt_next   = '0;
                    w_latch_next = 1'b0;
                end
            end
            CLEAR: begin
                if (w_arrival) begin
                    w_latch_next = 1'b1;
                end
                // an arrival on the exit cycle itself still re-opens a request
                if (!w_green) begin
                    w_latch_next = 1'b0;
                    if (r_latch || w_arrival) begin
                        w_state_next = REQ;
                        w_cnt_next   = c_cnt_one;
                    end else begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_latch        <= 1'b0;
            r_car_count    <= '0;
            r_x            <= 1'b0;
            r_served_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_timer        <= w_timer_next;
            r_latch        <= w_latch_next;
            r_car_count    <= w_cnt_next;
            r_x            <= (w_state_next == REQ) ||
                              ((w_state_next == SERVE) && ((w_timer_next != '0) || w_filt_next));
            r_served_pulse <= (w_state_next == CLEAR) && (r_state != CLEAR);
        end
    end

    assign x            = r_x;
    assign car_count    = r_car_count;
    assign served_pulse = r_served_pulse;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_country_sensor_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_country_sensor_interface
// Description : Scoreboard bench for country_sensor_interface: a behavioural
//               model predicts every cycle's outputs, a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_country_sensor_interface;

    localparam int D    = 4;
    localparam int M    = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          loop_raw;
    logic [1:0]    country_light;
    logic          x;
    logic [CW-1:0] car_count;
    logic          served_pulse;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] st;
        logic       x;
        logic [1:0] cnt;
        logic       pulse;
    } exp_t;

    exp_t exp_q[$];

    country_sensor_interface #(
        .DEBOUNCE_CYCLES (D),
        .MIN_SERVE_CYCLES(M),
        .CNT_W           (CW),
        .GREEN_CODE      (2'b10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .loop_raw     (loop_raw),
        .country_light(country_light),
        .x            (x),
        .car_count    (car_count),
        .served_pulse (served_pulse),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: filt follows s2 once the last D s2 samples all disagree with it
    int  m_st, m_timer, m_cnt, prev_st;
    bit  m_s1, m_s2, m_filt, m_filt_d, m_latch, m_pulse;
    bit  s2_hist[$];

    always @(posedge clk) begin : p_model
        bit   arrival, green, filt_old, flip;
        exp_t e;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_filt_d = 0; m_latch = 0; m_pulse = 0;
            m_st = 0; m_timer = 0; m_cnt = 0;
            s2_hist.delete();
        end else begin
            green    = (country_light == 2'b10);
            arrival  = m_filt && !m_filt_d;
            filt_old = m_filt;
            s2_hist.push_front(m_s2);
            if (s2_hist.size() > D) void'(s2_hist.pop_back());
            flip = (s2_hist.size() == D);
            foreach (s2_hist[i]) if (s2_hist[i] == filt_old) flip = 0;
            m_filt_d = filt_old;
            if (flip) m_filt = !filt_old;
            m_s2 = m_s1;
            m_s1 = loop_raw;
            prev_st = m_st;
            case (m_st)
                0: if (arrival) begin m_st = 1; m_cnt = 1; end
                1: begin
                    if (arrival) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                    if (green) begin m_st = 2; m_timer = M; end
                end
                2: begin
                    if (!green || (m_timer == 0 && !filt_old)) begin
                        m_st = 3; m_cnt = 0;
                    end else if (m_timer > 0) begin
                        m_timer--;
                    end
                end
                default: begin
                    if (arrival) m_latch = 1;
                    if (!green) begin
                        m_st    = m_latch ? 1 : 0;
                        m_cnt   = m_latch ? 1 : 0;
                        m_latch = 0;
                    end
                end
            endcase
            m_pulse = (m_st == 3) && (prev_st != 3);
        end
        e.st    = 2'(m_st);
        e.x     = (m_st == 1) || (m_st == 2 && (m_timer != 0 || m_filt));
        e.cnt   = 2'(m_cnt);
        e.pulse = m_pulse;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : p_monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_state", 32'(state), 32'(e.st));
            chk("sb_x", 32'(x), 32'(e.x));
            chk("sb_count", 32'(car_count), 32'(e.cnt));
            chk("sb_pulse", 32'(served_pulse), 32'(e.pulse));
        end
    end

    initial begin : p_stim
        int hold_l;
        rst = 1'b1; loop_raw = 1'b1; country_light = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_x", 32'(x), 0);
            chk("rst_state", 32'(state), 0);
            chk("rst_cnt", 32'(car_count), 0);
        end
        rst = 1'b0;
        tick(6); chk("latency_x_e6", 32'(x), 0);
        tick(1); chk("latency_x_e7", 32'(x), 1);
        chk("first_cnt", 32'(car_count), 1);

        loop_raw = 1'b0; tick(8);
        for (int k = 0; k < 4; k++) begin
            loop_raw = 1'b1; tick(8);
            chk("sat_cnt", 32'(car_count), (k == 0) ? 32'd2 : 32'd3);
            loop_raw = 1'b0; tick(8);
        end

        country_light = 2'b10;
        tick(1); chk("serve_state", 32'(state), 2); chk("serve_x", 32'(x), 1);
        tick(7); chk("hold_x", 32'(x), 1);
        tick(1); chk("hold_end_x", 32'(x), 0); chk("hold_end_state", 32'(state), 2);
        tick(1); chk("clear_state", 32'(state), 3); chk("clear_pulse", 32'(served_pulse), 1);
        chk("clear_cnt", 32'(car_count), 0);
        tick(1); chk("pulse_once", 32'(served_pulse), 0);

        loop_raw = 1'b1; tick(8); chk("clear_wait", 32'(state), 3);
        country_light = 2'b00;
        tick(1); chk("reopen_state", 32'(state), 1); chk("reopen_x", 32'(x), 1);
        chk("reopen_cnt", 32'(car_count), 1);

        country_light = 2'b10;
        tick(1); chk("pre_serve", 32'(state), 2);
        tick(3); country_light = 2'b01;
        tick(1); chk("preempt_state", 32'(state), 3); chk("preempt_pulse", 32'(served_pulse), 1);
        tick(1); chk("preempt_idle", 32'(state), 0);
        loop_raw = 1'b0; tick(8);

        loop_raw = 1'b1; tick(8); chk("mid_req", 32'(state), 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_x", 32'(x), 0); chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_cnt", 32'(car_count), 0); chk("mid_rst_pulse", 32'(served_pulse), 0);
        rst = 1'b0; loop_raw = 1'b0; tick(10);

        for (int g = 0; g < 5; g++) begin
            loop_raw = 1'b1; tick(3);
            loop_raw = 1'b0; tick(3);
            chk("glitch_x", 32'(x), 0); chk("glitch_state", 32'(state), 0);
        end

        hold_l = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold_l == 0) begin
                loop_raw = 1'($urandom_range(0, 1));
                hold_l   = $urandom_range(1, 12);
            end
            hold_l--;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: country_light = 2'b00;
                    1: country_light = 2'b01;
                    2: country_light = 2'b11;
                    default: country_light = 2'b10;
                endcase
            end
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end

        rst = 1'b0; loop_raw = 1'b0;
        tick(2);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
